// File: rtl/mips_mc_decode.sv
// mips_mc_decode: multi-cycle MIPS control unit.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. Memory
// accesses use a req/ready handshake guarded by a MEM_TIMEOUT-cycle watchdog.
// Optional feature macro: MIPS_MC_ADDM_EN (adds addm: rd = rs + Mem[rt]).
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct, zero   IR fields and ALU zero flag
//   mem_ready             memory completes the current request
//   mem_req/mem_we/byte_en/iord, ir_we, pc_we, control_type,
//   alu_op, alu_src2, rd_src, reg_we, mem_to_reg   datapath controls
//   slt, lui, addm        instruction-class flags (DECODE..WB)
//   except, state, retired sticky exception, debug state, retire count
module mips_mc_decode #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                byte_en,
    output logic                iord,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          control_type,
    output logic [2:0]          alu_op,
    output logic [1:0]          alu_src2,
    output logic                rd_src,
    output logic                reg_we,
    output logic                mem_to_reg,
    output logic                slt,
    output logic                lui,
    output logic                addm,
    output logic                except,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OP_OTHER0 = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] OP0_JR    = 6'h08;
    localparam logic [5:0] OP0_ADD   = 6'h20;
    localparam logic [5:0] OP0_SUB   = 6'h22;
    localparam logic [5:0] OP0_AND   = 6'h24;
    localparam logic [5:0] OP0_OR    = 6'h25;
    localparam logic [5:0] OP0_XOR   = 6'h26;
    localparam logic [5:0] OP0_NOR   = 6'h27;
    localparam logic [5:0] OP0_SLT   = 6'h2a;
`ifdef MIPS_MC_ADDM_EN
    localparam logic [5:0] OP0_ADDM  = 6'h2c;
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_EXC    = 3'd7
    } state_t;

    state_t                r_state, w_next;
    logic [WAIT_W-1:0]     r_wait;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  r_except;
    logic                  w_retire, w_timeout, w_in_instr;

    logic                  w_ok, w_load, w_store, w_byte, w_beq, w_bne;
    logic                  w_j, w_jr, w_addm, w_slt, w_lui, w_rd_rt;
    logic [2:0]            w_op;
    logic [1:0]            w_src2;

    // Instruction decode from the IR fields
    always_comb begin
        w_ok = 1'b1; w_load = 1'b0; w_store = 1'b0; w_byte = 1'b0;
        w_beq = 1'b0; w_bne = 1'b0; w_j = 1'b0; w_jr = 1'b0;
        w_addm = 1'b0; w_slt = 1'b0; w_lui = 1'b0; w_rd_rt = 1'b0;
        w_op = 3'b010; w_src2 = 2'b00;
        case (opcode)
            OP_OTHER0: begin
                case (funct)
                    OP0_ADD: w_op = 3'b010;
                    OP0_SUB: w_op = 3'b011;
                    OP0_AND: w_op = 3'b100;
                    OP0_OR:  w_op = 3'b101;
                    OP0_NOR: w_op = 3'b110;
                    OP0_XOR: w_op = 3'b111;
                    OP0_SLT: begin w_op = 3'b011; w_slt = 1'b1; end
                    OP0_JR:  w_jr = 1'b1;
`ifdef MIPS_MC_ADDM_EN
                    OP0_ADDM: w_addm = 1'b1;
`endif
                    default: w_ok = 1'b0;
                endcase
            end
            OP_ADDI: begin w_src2 = 2'b01; w_rd_rt = 1'b1; end
            OP_SLTI: begin w_op = 3'b011; w_src2 = 2'b01; w_rd_rt = 1'b1; w_slt = 1'b1; end
            OP_ANDI: begin w_op = 3'b100; w_src2 = 2'b10; w_rd_rt = 1'b1; end
            OP_ORI:  begin w_op = 3'b101; w_src2 = 2'b10; w_rd_rt = 1'b1; end
            OP_XORI: begin w_op = 3'b111; w_src2 = 2'b10; w_rd_rt = 1'b1; end
            OP_LUI:  begin w_src2 = 2'b10; w_rd_rt = 1'b1; w_lui = 1'b1; end
            OP_LW:   begin w_src2 = 2'b01; w_rd_rt = 1'b1; w_load = 1'b1; end
            OP_LBU:  begin w_src2 = 2'b01; w_rd_rt = 1'b1; w_load = 1'b1; w_byte = 1'b1; end
            OP_SW:   begin w_src2 = 2'b01; w_store = 1'b1; end
            OP_SB:   begin w_src2 = 2'b01; w_store = 1'b1; w_byte = 1'b1; end
            OP_BEQ:  begin w_op = 3'b011; w_beq = 1'b1; end
            OP_BNE:  begin w_op = 3'b011; w_bne = 1'b1; end
            OP_J:    w_j = 1'b1;
            default: w_ok = 1'b0;
        endcase
    end

    // Timeout fires on the MEM_TIMEOUT-th consecutive unanswered request cycle
    assign w_timeout  = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_in_instr = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                        (r_state == S_MEM)    || (r_state == S_WB);

    // Next-state and control decode
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        byte_en      = 1'b0;
        iord         = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        control_type = 2'b00;
        alu_op       = 3'b000;
        alu_src2     = 2'b00;
        rd_src       = 1'b0;
        reg_we       = 1'b0;
        mem_to_reg   = 1'b0;
        slt          = w_in_instr && w_slt;
        lui          = w_in_instr && w_lui;
        addm         = w_in_instr && w_addm;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_EXC;
                end
            end
            S_DECODE: begin
                if (!w_ok) begin
                    w_next = S_EXC;
                end else if (w_j || w_jr) begin
                    pc_we        = 1'b1;
                    control_type = w_j ? 2'b10 : 2'b11;
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end else if (w_addm) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op   = w_op;
                alu_src2 = w_src2;
                rd_src   = w_rd_rt;
                if (w_addm) begin
                    mem_to_reg = 1'b1;
                    w_next     = S_WB;
                end else if (w_load || w_store) begin
                    w_next = S_MEM;
                end else if (w_beq || w_bne) begin
                    if ((w_beq && zero) || (w_bne && !zero)) begin
                        pc_we        = 1'b1;
                        control_type = 2'b01;
                    end
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = w_store;
                byte_en = w_byte;
                rd_src  = w_rd_rt;
                if (w_addm) begin
                    // Address comes from rt through the ALU
                    alu_op   = w_op;
                    alu_src2 = w_src2;
                end
                if (mem_ready) begin
                    if (w_addm) begin
                        w_next = S_EXEC;
                    end else if (w_load) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next = S_EXC;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = w_load;
                rd_src     = w_rd_rt;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXC: w_next = S_EXC;
            default: w_next = S_EXC;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Wait counter restarts on every state change, counts unanswered requests
    always_ff @(posedge clock) begin
        if (reset)                     r_wait <= '0;
        else if (w_next != r_state)    r_wait <= '0;
        else if (mem_req && !mem_ready) r_wait <= r_wait + WAIT_W'(1);
    end

    // Retire counter and sticky exception
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired <= '0;
            r_except  <= 1'b0;
        end else begin
            if (w_retire)         r_retired <= r_retired + RETIRE_W'(1);
            if (w_next == S_EXC)  r_except  <= 1'b1;
        end
    end

    assign state   = r_state;
    assign retired = r_retired;
    assign except  = r_except;

endmodule
